// File: rtl/snake_body_scanner.sv
// Scans the snake segment memory for the lowest-index segment occupying a queried cell.
// One address per cycle with a one-cycle read latency; stops at the first match.
module snake_body_scanner #(
    parameter  int unsigned MAX_LEN = 64,
    parameter  int unsigned COORD_W = 6,
    localparam int unsigned IDX_W   = $clog2(MAX_LEN),
    localparam int unsigned LEN_W   = IDX_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               query_valid,
    output logic               query_ready,
    input  logic [COORD_W-1:0] query_x,
    input  logic [COORD_W-1:0] query_y,
    input  logic [LEN_W-1:0]   snake_len,
    input  logic               skip_head,
    output logic [IDX_W-1:0]   seg_addr,
    input  logic [COORD_W-1:0] seg_x,
    input  logic [COORD_W-1:0] seg_y,
    output logic               result_valid,
    output logic               result_hit,
    output logic [IDX_W-1:0]   result_idx
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state;
    logic [COORD_W-1:0] qx;
    logic [COORD_W-1:0] qy;
    logic [LEN_W-1:0]   qlen;
    logic               cmp_vld;
    logic [IDX_W-1:0]   cmp_idx;

    logic [LEN_W-1:0]   eff_len;
    logic               empty;
    logic               match;
    logic               last;

    // Acceptance-time decode and compare on the data returned for cmp_idx
    always_comb begin
        eff_len = (snake_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : snake_len;
        empty   = (eff_len == '0) || (skip_head && (eff_len == LEN_W'(1)));
        match   = cmp_vld && (seg_x == qx) && (seg_y == qy);
        last    = cmp_vld && ((LEN_W'(cmp_idx) + LEN_W'(1)) == qlen);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            query_ready  <= 1'b0;
            result_valid <= 1'b0;
            result_hit   <= 1'b0;
            result_idx   <= '0;
            seg_addr     <= '0;
            qx           <= '0;
            qy           <= '0;
            qlen         <= '0;
            cmp_vld      <= 1'b0;
            cmp_idx      <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    query_ready <= 1'b1;
                    if (query_valid && query_ready) begin
                        query_ready <= 1'b0;
                        qx          <= query_x;
                        qy          <= query_y;
                        qlen        <= eff_len;
                        cmp_vld     <= 1'b0;
                        if (empty) begin
                            state        <= DONE;
                            result_valid <= 1'b1;
                            result_hit   <= 1'b0;
                            result_idx   <= '0;
                        end else begin
                            state    <= SCAN;
                            seg_addr <= IDX_W'(skip_head);
                        end
                    end
                end
                SCAN: begin
                    // Keep prefetching; the address saturates at the last valid entry
                    cmp_vld <= 1'b1;
                    cmp_idx <= seg_addr;
                    if ((LEN_W'(seg_addr) + LEN_W'(1)) < qlen) begin
                        seg_addr <= seg_addr + IDX_W'(1);
                    end
                    if (match) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        result_hit   <= 1'b1;
                        result_idx   <= cmp_idx;
                    end else if (last) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        result_hit   <= 1'b0;
                        result_idx   <= '0;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    query_ready <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    query_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_body_scanner.sv
// Self-checking bench for snake_body_scanner: directed cases plus random queries
// compared against a linear-search reference model over a bench-owned segment memory.
module tb_snake_body_scanner;

    localparam int unsigned MAX_LEN = 64;
    localparam int unsigned COORD_W = 6;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned LEN_W   = 7;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               query_valid;
    logic               query_ready;
    logic [COORD_W-1:0] query_x;
    logic [COORD_W-1:0] query_y;
    logic [LEN_W-1:0]   snake_len;
    logic               skip_head;
    logic [IDX_W-1:0]   seg_addr;
    logic [COORD_W-1:0] seg_x;
    logic [COORD_W-1:0] seg_y;
    logic               result_valid;
    logic               result_hit;
    logic [IDX_W-1:0]   result_idx;

    logic [COORD_W-1:0] mem_x [MAX_LEN];
    logic [COORD_W-1:0] mem_y [MAX_LEN];

    int errors = 0;
    int checks = 0;

    snake_body_scanner #(.MAX_LEN(MAX_LEN), .COORD_W(COORD_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .query_valid  (query_valid),
        .query_ready  (query_ready),
        .query_x      (query_x),
        .query_y      (query_y),
        .snake_len    (snake_len),
        .skip_head    (skip_head),
        .seg_addr     (seg_addr),
        .seg_x        (seg_x),
        .seg_y        (seg_y),
        .result_valid (result_valid),
        .result_hit   (result_hit),
        .result_idx   (result_idx)
    );

    always #5 clk = ~clk;

    // Synchronous segment memory: data follows the address by one cycle
    always @(posedge clk) begin
        seg_x <= mem_x[seg_addr];
        seg_y <= mem_y[seg_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill_line();
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            mem_x[i] = COORD_W'(i);
            mem_y[i] = '0;
        end
    endtask

    // Reference: linear search for the lowest matching index in the scanned range.
    // Latency counts cycles after the accepting edge until result_valid is seen.
    task automatic model(input int qx, input int qy, input int len_in, input int skip,
                         output int lat, output int hit, output int idx, output int n, output int s);
        int len;
        len = (len_in > int'(MAX_LEN)) ? int'(MAX_LEN) : len_in;
        s   = skip;
        n   = len - s;
        hit = 0;
        idx = 0;
        lat = n + 2;
        if (n <= 0) begin
            lat = 1;
        end else begin
            for (int j = s; j < len; j++) begin
                if (hit == 0 && int'(mem_x[j]) == qx && int'(mem_y[j]) == qy) begin
                    hit = 1;
                    idx = j;
                    lat = (j - s) + 3;
                end
            end
        end
    endtask

    task automatic run_query(input string tag, input int qx, input int qy, input int len_in,
                             input int skip, output int peak);
        int exp_lat, exp_hit, exp_idx, n, s;
        int got_lat, got_hit, got_idx, pulses, w;
        bit addr_ok;
        model(qx, qy, len_in > 127 ? 64 : len_in, skip, exp_lat, exp_hit, exp_idx, n, s);
        @(negedge clk);
        query_x     = COORD_W'(qx);
        query_y     = COORD_W'(qy);
        snake_len   = LEN_W'(len_in);
        skip_head   = skip[0];
        query_valid = 1'b1;
        w = 0;
        while (!query_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready"}, 32'(query_ready), 32'd1);
        @(posedge clk);
        got_lat = -1; got_hit = -1; got_idx = -1;
        pulses = 0; addr_ok = 1'b1; peak = 0;
        for (int c = 1; c <= exp_lat + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Scramble the inputs: the query in flight must use latched values
                query_valid = 1'b0;
                query_x     = COORD_W'($urandom);
                query_y     = COORD_W'($urandom);
                snake_len   = LEN_W'($urandom);
                skip_head   = 1'($urandom);
            end
            if (c < exp_lat && c - 1 < n && int'(seg_addr) != s + c - 1) addr_ok = 1'b0;
            if (int'(seg_addr) > peak) peak = int'(seg_addr);
            if (result_valid) begin
                pulses++;
                if (got_lat < 0) begin
                    got_lat = c;
                    got_hit = int'(result_hit);
                    got_idx = int'(result_idx);
                end
            end
        end
        check({tag, "_latency"}, 32'(got_lat), 32'(exp_lat));
        check({tag, "_hit"}, 32'(got_hit), 32'(exp_hit));
        check({tag, "_idx"}, 32'(got_idx), 32'(exp_idx));
        check({tag, "_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_addr_seq"}, 32'(addr_ok), 32'd1);
        check({tag, "_hold_hit"}, 32'(result_hit), 32'(exp_hit));
        check({tag, "_hold_idx"}, 32'(result_idx), 32'(exp_idx));
    endtask

    initial begin
        int peak, pulse_cnt, p1, p2, h2, i2, first_ready;
        int e_lat, e_hit, e_idx, e_n, e_s;

        rst_n = 1'b0; query_valid = 1'b0; query_x = '0; query_y = '0;
        snake_len = '0; skip_head = 1'b0;
        fill_line();
        #1;
        check("rst_ready", 32'(query_ready), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_hit", 32'(result_hit), 32'd0);
        check("rst_idx", 32'(result_idx), 32'd0);
        check("rst_addr", 32'(seg_addr), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(query_ready), 32'd1);

        // Line memory (i,0)
        run_query("hit_idx2", 2, 0, 5, 0, peak);
        run_query("full_miss", 9, 9, 5, 0, peak);

        mem_x[0] = 6'd5; mem_y[0] = 6'd5;
        mem_x[1] = 6'd6; mem_y[1] = 6'd5;
        mem_x[2] = 6'd5; mem_y[2] = 6'd5;
        run_query("skip_head", 5, 5, 3, 1, peak);
        run_query("no_skip", 5, 5, 3, 0, peak);
        run_query("len0", 0, 0, 0, 0, peak);
        run_query("len1_skip", 5, 5, 1, 1, peak);

        fill_line();
        run_query("len200_clamp", 9, 9, 200, 0, peak);
        check("len200_peak", 32'(peak), 32'd63);
        run_query("hit_last63", 63, 0, 200, 0, peak);

        // Reset three cycles after accept must abort silently
        @(negedge clk);
        query_x = 6'd40; query_y = 6'd0; snake_len = 7'd50; skip_head = 1'b0; query_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); query_valid = 1'b0;
        pulse_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (result_valid) pulse_cnt++;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(result_valid), 32'd0);
        check("midrst_addr", 32'(seg_addr), 32'd0);
        check("midrst_ready", 32'(query_ready), 32'd0);
        check("midrst_idx", 32'(result_idx), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (result_valid) pulse_cnt++;
            if (c == 0) check("midrst_ready_release", 32'(query_ready), 32'd1);
        end
        check("midrst_no_pulse", 32'(pulse_cnt), 32'd0);

        // Back-to-back with query_valid held high and inputs changed mid-scan
        fill_line();
        @(negedge clk);
        query_x = 6'd9; query_y = 6'd9; snake_len = 7'd5; skip_head = 1'b0; query_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        query_x = 6'd1; query_y = 6'd0; snake_len = 7'd2;
        model(1, 0, 2, 0, e_lat, e_hit, e_idx, e_n, e_s);
        p1 = -1; p2 = -1; h2 = -1; i2 = -1; first_ready = -1; pulse_cnt = 0;
        for (int c = 2; c <= 16; c++) begin
            @(negedge clk);
            if (query_ready && first_ready < 0) first_ready = c;
            if (c == first_ready + 1 && first_ready > 0) query_valid = 1'b0;
            if (result_valid) begin
                pulse_cnt++;
                if (p1 < 0) begin
                    p1 = c;
                    check("b2b_first_hit", 32'(result_hit), 32'd0);
                end else if (p2 < 0) begin
                    p2 = c; h2 = int'(result_hit); i2 = int'(result_idx);
                end
            end
        end
        check("b2b_first_latency", 32'(p1), 32'd7);
        check("b2b_ready_after_done", 32'(first_ready), 32'd8);
        check("b2b_second_latency", 32'(p2), 32'(8 + e_lat));
        check("b2b_second_hit", 32'(h2), 32'(e_hit));
        check("b2b_second_idx", 32'(i2), 32'(e_idx));
        check("b2b_pulses", 32'(pulse_cnt), 32'd2);

        // Random memories over a small coordinate range so hits are common
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                mem_x[i] = COORD_W'($urandom_range(0, 3));
                mem_y[i] = COORD_W'($urandom_range(0, 3));
            end
            run_query("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 70)), int'($urandom_range(0, 1)), peak);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_body_scanner.md
SNAKE_BODY_SCANNER -- requirements
Module: snake_body_scanner

Interface
REQ-001 Parameter MAX_LEN, default 64: capacity of the snake segment memory, in segments.
REQ-002 Parameter COORD_W, default 6: width of one grid coordinate.
REQ-003 Derived widths: IDX_W = clog2(MAX_LEN); LEN_W = IDX_W+1.
REQ-004 CLK  input  1  single system clock; all logic is rising-edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 query_valid  input  1  a query request is presented.
REQ-007 query_ready  output  1  the block accepts a query this cycle.
REQ-008 query_x, query_y  input  COORD_W each  grid cell under test.
REQ-009 snake_len  input  LEN_W  current segment count; segment 0 is the head.
REQ-010 skip_head  input  1  excludes segment 0 from the scan (head self-collision check).
REQ-011 seg_addr  output  IDX_W  read address into the segment memory owned by SnakeMover.
REQ-012 seg_x, seg_y  input  COORD_W each  segment data; valid exactly one cycle after seg_addr.
REQ-013 result_valid  output  1  one-cycle pulse; the result fields are valid.
REQ-014 result_hit  output  1  the queried cell is occupied by a scanned segment.
REQ-015 result_idx  output  IDX_W  lowest matching segment index; 0 when there is no hit.

Function
REQ-016 The FSM SHALL have the states IDLE, SCAN and DONE.
REQ-017 query_ready SHALL be 1 only in IDLE.
REQ-018 A query SHALL be accepted on a rising edge where query_valid=1 and query_ready=1; that edge is edge k.
REQ-019 At acceptance the block SHALL latch query_x, query_y, skip_head and the effective length.
- Effective length = min(snake_len, MAX_LEN).
- Later changes to any of these inputs SHALL NOT affect the query in progress.
REQ-020 Scan range: start index s = skip_head ? 1 : 0; entries s .. len-1; count n = len - s.
REQ-021 Empty scan (n <= 0): IDLE -> DONE at edge k, with hit=0 and idx=0; result_valid is high in cycle k+1.
REQ-022 Non-empty scan: IDLE -> SCAN at edge k.
- seg_addr = s + i during cycle k+1+i.
- One address is issued per cycle, with no gaps.
REQ-023 Compare step: the data for offset i SHALL be compared in cycle k+2+i as seg_x==qx AND seg_y==qy.
REQ-024 On the first match at offset i, the block SHALL go SCAN -> DONE.
- result_hit=1 and result_idx=s+i.
- result_valid is high in cycle k+3+i.
REQ-025 Early termination: after a hit, no further compare SHALL change the result; extra prefetched addresses are harmless.
REQ-026 Miss: after offset n-1 compares with no match, the block SHALL go SCAN -> DONE with hit=0, idx=0.
- result_valid is high in cycle k+2+n.
REQ-027 DONE SHALL last exactly one cycle and then return to IDLE.
- result_valid=1 only in DONE.
- result_hit and result_idx hold their values until the next DONE.
REQ-028 query_valid asserted during SCAN or DONE SHALL NOT be accepted.
- It is accepted at the first IDLE edge.
- The earliest back-to-back accept is the cycle after DONE.
REQ-029 seg_addr SHALL never exceed MAX_LEN-1.
- In IDLE and DONE, seg_addr holds its last value.
- The memory read has no side effects.
REQ-030 Coordinate compare SHALL be full COORD_W equality, with no wrap or sign interpretation.

Reset
REQ-031 RST_N=0 SHALL asynchronously force the following:
- state = IDLE;
- query_ready = 0 while reset is asserted;
- result_valid = 0, result_hit = 0, result_idx = 0;
- seg_addr = 0;
- all latched query registers = 0.
REQ-032 query_ready SHALL rise in the first cycle after RST_N deasserts.
REQ-033 Reset during SCAN or DONE SHALL abort the query with no result_valid pulse.

Verification
REQ-034 Hit at index 2:
- Stimulus: len=5, skip_head=0, memory (0,0),(1,0),(2,0),(3,0),(4,0), query (2,0) accepted at edge k.
- Response: result_valid in cycle k+5, hit=1, idx=2; seg_addr sequence 0,1,2,...
REQ-035 Full miss:
- Stimulus: same memory, query (9,9).
- Response: result_valid in cycle k+7, hit=0, idx=0; exactly one pulse.
REQ-036 skip_head:
- Stimulus: len=3, memory (5,5),(6,5),(5,5), skip_head=1, query (5,5).
- Response: hit=1, idx=2; seg_addr starts at 1.
REQ-037 Empty cases:
- len=0, skip_head=0 -> result_valid in cycle k+1, hit=0.
- len=1, skip_head=1 -> result_valid in cycle k+1, hit=0.
- len=200 clamps to MAX_LEN=64: a miss takes 64+2 cycles and seg_addr peaks at 63.
REQ-038 Reset mid-scan:
- Stimulus: RST_N low 3 cycles after accept.
- Response: outputs are 0 immediately, no result pulse, query_ready=1 one cycle after release.
REQ-039 Back-to-back queries:
- Stimulus: query_valid held high with snake_len changing mid-scan.
- Response: the second query is accepted the cycle after DONE; the first result uses the latched length.
